// File: rtl/sap_microseq_ctrl_if.sv
// Bundle between the instruction/flags registers and the SAP micro-step sequencer.
// SAP_SINGLE_STEP_EN adds the step_req request line.
interface sap_microseq_ctrl_if #(
    parameter int OPC_W  = 4,
    parameter int STEP_W = 3
);
    logic [OPC_W-1:0]  instruction;
    logic              flag_carry;
    logic              flag_zero;
    logic [15:0]       ctrl_word;
    logic [STEP_W-1:0] step;
    logic              halted;
`ifdef SAP_SINGLE_STEP_EN
    logic              step_req;

    modport master (
        output instruction, flag_carry, flag_zero, step_req,
        input  ctrl_word, step, halted
    );
    modport slave (
        input  instruction, flag_carry, flag_zero, step_req,
        output ctrl_word, step, halted
    );
`else
    modport master (
        output instruction, flag_carry, flag_zero,
        input  ctrl_word, step, halted
    );
    modport slave (
        input  instruction, flag_carry, flag_zero,
        output ctrl_word, step, halted
    );
`endif
endinterface

// File: rtl/sap_microseq_ctrl.sv
// SAP micro-step sequencer: registered 16-bit control word issued on every falling edge.
// Optional SAP_SINGLE_STEP_EN gates each micro-step with step_req.
module sap_microseq_ctrl #(
    parameter int OPC_W     = 4,
    parameter int STEP_W    = 3,
    parameter int MAX_STEPS = 6
) (
    input  logic                clk,
    input  logic                reset,
    sap_microseq_ctrl_if.slave  bus
);
    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            r_state, w_state_next;
    logic [15:0]       r_ctrl, w_ctrl_next;
    logic [STEP_W-1:0] r_step, w_step_next;
    logic [STEP_W-1:0] r_ptr, w_ptr_next;
    logic [31:0]       w_opc;
    logic              w_advance;

    function automatic logic [15:0] f_uop(input logic [31:0] opc, input int t,
                                          input logic fc, input logic fz);
        logic [15:0] u;
        u = '0;
        if (t == 0) begin
            u = C_MI | C_CO;
        end else if (t == 1) begin
            u = C_RO | C_II | C_CE;
        end else begin
            case (opc)
                32'd1: case (t)
                    2:       u = C_IO | C_MI;
                    3:       u = C_RO | C_AI;
                    default: u = '0;
                endcase
                32'd2: case (t)
                    2:       u = C_IO | C_MI;
                    3:       u = C_RO | C_BI;
                    4:       u = C_EO | C_AI | C_FI;
                    default: u = '0;
                endcase
                32'd3: case (t)
                    2:       u = C_IO | C_MI;
                    3:       u = C_RO | C_BI;
                    4:       u = C_EO | C_SU | C_AI | C_FI;
                    default: u = '0;
                endcase
                32'd4: case (t)
                    2:       u = C_IO | C_MI;
                    3:       u = C_RI | C_AO;
                    default: u = '0;
                endcase
                32'd5:  if (t == 2) u = C_IO | C_AI;
                32'd6:  if (t == 2) u = C_IO | C_J;
                32'd7:  if (t == 2 && fc) u = C_IO | C_J;
                32'd8:  if (t == 2 && fz) u = C_IO | C_J;
                32'd14: if (t == 2) u = C_AO | C_OI;
                32'd15: if (t == 2) u = C_HLT;
                default: u = '0;
            endcase
        end
        return u;
    endfunction

    // Index of the final micro-step of each microprogram (fetch alone ends at 1).
    function automatic int f_last(input logic [31:0] opc);
        case (opc)
            32'd1, 32'd4:                                   return 3;
            32'd2, 32'd3:                                   return 4;
            32'd5, 32'd6, 32'd7, 32'd8, 32'd14, 32'd15:     return 2;
            default:                                        return 1;
        endcase
    endfunction

    assign w_opc = 32'(bus.instruction);
`ifdef SAP_SINGLE_STEP_EN
    assign w_advance = bus.step_req;
`else
    assign w_advance = 1'b1;
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_ctrl  <= '0;
            r_step  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= w_ctrl_next;
            r_step  <= w_step_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctrl_next  = r_ctrl;
        w_step_next  = r_step;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_RUN: begin
                if (w_advance) begin
                    // Flags are read here, at the edge that issues the jump step.
                    w_ctrl_next = f_uop(w_opc, int'(r_ptr), bus.flag_carry, bus.flag_zero);
                    w_step_next = r_ptr;
                    if (int'(r_ptr) >= f_last(w_opc) || int'(r_ptr) >= MAX_STEPS - 1)
                        w_ptr_next = '0;
                    else
                        w_ptr_next = r_ptr + 1'b1;
                    if (w_opc == 32'd15 && int'(r_ptr) == 2)
                        w_state_next = ST_HALT;
                end else begin
                    w_ctrl_next = '0;
                end
            end
            ST_HALT: begin
                w_ctrl_next = C_HLT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign bus.ctrl_word = r_ctrl;
    assign bus.step      = r_step;
    assign bus.halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_sap_microseq_ctrl.sv
// Bench for sap_microseq_ctrl: opcode table, hand-written halt/reset/limit sequences,
// and random instruction streams checked against a microprogram-list model.
module tb_sap_microseq_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sap_microseq_ctrl_if #(.OPC_W(4), .STEP_W(3)) bus  ();
    sap_microseq_ctrl_if #(.OPC_W(4), .STEP_W(3)) bus4 ();

    sap_microseq_ctrl #(.OPC_W(4), .STEP_W(3), .MAX_STEPS(6)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    sap_microseq_ctrl #(.OPC_W(4), .STEP_W(3), .MAX_STEPS(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    typedef logic [15:0] wq_t[$];

    typedef struct {
        logic [3:0]  opc;
        logic        fc;
        logic        fz;
        int          len;
        logic [15:0] ex2;
        logic [15:0] ex3;
        logic [15:0] ex4;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp_main(input string nm, input logic [15:0] w, input int s, input logic h);
        chk({nm, " word"},   32'(bus.ctrl_word), 32'(w));
        chk({nm, " step"},   32'(bus.step),      32'(s));
        chk({nm, " halted"}, 32'(bus.halted),    32'(h));
    endtask

    task automatic exp_four(input string nm, input logic [15:0] w, input int s);
        chk({nm, " word4"}, 32'(bus4.ctrl_word), 32'(w));
        chk({nm, " step4"}, 32'(bus4.step),      32'(s));
    endtask

    // Outputs change on the falling edge; look at them 1 time unit later.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_main("reset_async", 16'h0000, 0, 1'b0);
        exp_four("reset_async", 16'h0000, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference: fetch plus the opcode's execute list, cut to the step limit.
    function automatic wq_t model(input int opc, input bit fc, input bit fz, input int max_steps);
        wq_t q;
        q.push_back(16'h4004);
        q.push_back(16'h1408);
        case (opc)
            1:  begin q.push_back(16'h4800); q.push_back(16'h1200); end
            2:  begin q.push_back(16'h4800); q.push_back(16'h1020); q.push_back(16'h0281); end
            3:  begin q.push_back(16'h4800); q.push_back(16'h1020); q.push_back(16'h02C1); end
            4:  begin q.push_back(16'h4800); q.push_back(16'h2100); end
            5:  q.push_back(16'h0A00);
            6:  q.push_back(16'h0802);
            7:  q.push_back(fc ? 16'h0802 : 16'h0000);
            8:  q.push_back(fz ? 16'h0802 : 16'h0000);
            14: q.push_back(16'h0110);
            15: q.push_back(16'h8000);
            default: ;
        endcase
        while (q.size() > max_steps) void'(q.pop_back());
        return q;
    endfunction

    initial begin
        logic [15:0] w;
        wq_t         q;
        int          opc;
        bit          fc, fz;
        logic [15:0] seq_w  [5];
        int          seq_s  [5];
        logic [15:0] seq_w4 [5];

        bus.instruction  = 4'h1;
        bus.flag_carry   = 1'b0;
        bus.flag_zero    = 1'b0;
        bus4.instruction = 4'h0;
        bus4.flag_carry  = 1'b0;
        bus4.flag_zero   = 1'b0;
`ifdef SAP_SINGLE_STEP_EN
        bus.step_req  = 1'b1;
        bus4.step_req = 1'b1;
`endif

        tbl.push_back('{4'h1, 1'b0, 1'b0, 4, 16'h4800, 16'h1200, 16'h0000});
        tbl.push_back('{4'h2, 1'b0, 1'b0, 5, 16'h4800, 16'h1020, 16'h0281});
        tbl.push_back('{4'h3, 1'b1, 1'b1, 5, 16'h4800, 16'h1020, 16'h02C1});
        tbl.push_back('{4'h4, 1'b0, 1'b0, 4, 16'h4800, 16'h2100, 16'h0000});
        tbl.push_back('{4'h5, 1'b0, 1'b0, 3, 16'h0A00, 16'h0000, 16'h0000});
        tbl.push_back('{4'h6, 1'b0, 1'b0, 3, 16'h0802, 16'h0000, 16'h0000});
        tbl.push_back('{4'h7, 1'b0, 1'b1, 3, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{4'h7, 1'b1, 1'b0, 3, 16'h0802, 16'h0000, 16'h0000});
        tbl.push_back('{4'h8, 1'b1, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{4'h8, 1'b0, 1'b1, 3, 16'h0802, 16'h0000, 16'h0000});
        tbl.push_back('{4'hE, 1'b0, 1'b0, 3, 16'h0110, 16'h0000, 16'h0000});
        tbl.push_back('{4'h0, 1'b0, 1'b0, 2, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{4'h9, 1'b1, 1'b1, 2, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{4'hD, 1'b0, 1'b0, 2, 16'h0000, 16'h0000, 16'h0000});
        tbl.push_back('{4'h1, 1'b0, 1'b0, 4, 16'h4800, 16'h1200, 16'h0000});

        #2;
        do_reset();
        exp_main("reset_released", 16'h0000, 0, 1'b0);

        // Opcode table, each instruction starting on a T0 boundary.
        foreach (tbl[i]) begin
            bus.instruction = tbl[i].opc;
            bus.flag_carry  = tbl[i].fc;
            bus.flag_zero   = tbl[i].fz;
            for (int k = 0; k < tbl[i].len; k++) begin
                case (k)
                    0:       w = 16'h4004;
                    1:       w = 16'h1408;
                    2:       w = tbl[i].ex2;
                    3:       w = tbl[i].ex3;
                    default: w = tbl[i].ex4;
                endcase
                cyc();
                exp_main($sformatf("tbl%0d_op%0h_t%0d", i, tbl[i].opc, k), w, k, 1'b0);
            end
            $display("table %0d opcode 0x%0h c=%0b z=%0b steps=%0d", i, tbl[i].opc,
                     tbl[i].fc, tbl[i].fz, tbl[i].len);
        end

        // Random instruction stream against the list model.
        for (int n = 0; n < 120; n++) begin
            opc = int'($urandom_range(0, 14));
            fc  = 1'($urandom_range(0, 1));
            fz  = 1'($urandom_range(0, 1));
            q   = model(opc, fc, fz, 6);
            bus.instruction = 4'(opc);
            bus.flag_carry  = fc;
            bus.flag_zero   = fz;
            for (int k = 0; k < q.size(); k++) begin
                cyc();
                exp_main($sformatf("rnd%0d_op%0h_t%0d", n, opc, k), q[k], k, 1'b0);
            end
            $display("random %0d opcode 0x%0h c=%0b z=%0b steps=%0d", n, opc, fc, fz, q.size());
        end

        // Sticky halt: inputs wander, outputs must not.
        bus.instruction = 4'hF;
        cyc(); exp_main("hlt_t0", 16'h4004, 0, 1'b0);
        cyc(); exp_main("hlt_t1", 16'h1408, 1, 1'b0);
        cyc(); exp_main("hlt_t2", 16'h8000, 2, 1'b1);
        for (int n = 0; n < 20; n++) begin
            bus.instruction = 4'($urandom_range(0, 15));
            bus.flag_carry  = 1'($urandom_range(0, 1));
            cyc();
            exp_main($sformatf("halted_%0d", n), 16'h8000, 2, 1'b1);
        end
        $display("halt held for 20 clocks");
        @(posedge clk);
        #3;
        bus.instruction = 4'h1;
        do_reset();

        // Reset while LDA is in T1, then a clean restart on both limits.
        cyc(); exp_main("lda_pre_t0", 16'h4004, 0, 1'b0);
        cyc(); exp_main("lda_pre_t1", 16'h1408, 1, 1'b0);
        #2;
        bus4.instruction = 4'h2;
        do_reset();
        seq_w  = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004};
        seq_s  = '{0, 1, 2, 3, 0};
        seq_w4 = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h4004};
        for (int k = 0; k < 5; k++) begin
            cyc();
            exp_main($sformatf("restart_t%0d", k), seq_w[k], seq_s[k], 1'b0);
            exp_four($sformatf("limit4_add_t%0d", k), seq_w4[k], seq_s[k]);
        end
        $display("restart after mid-instruction reset; ADD truncated at 4 steps");

`ifdef SAP_SINGLE_STEP_EN
        bus.step_req    = 1'b0;
        bus.instruction = 4'h1;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            cyc();
            exp_main($sformatf("ss_idle_%0d", n), 16'h0000, 0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            bus.step_req = 1'b1;
            cyc();
            exp_main($sformatf("ss_pulse_%0d", k), seq_w[k], seq_s[k], 1'b0);
            bus.step_req = 1'b0;
            cyc();
            exp_main($sformatf("ss_gap_%0d", k), 16'h0000, seq_s[k], 1'b0);
        end
        $display("single-step: 10 idle clocks then 5 request pulses");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
